alu_seq_param: RTL and testbench
================================

Name: alu_seq_param

Overview:
- Parametrised, registered successor to the team's 32-bit combinational ALU.
- Adds XOR, an iterative shift-add multiplier, and signed overflow and negative flags.
- Adds a valid/ready input handshake and registered, held outputs.
- Sits between the operand register file and the writeback stage of the lab datapath.
- Single-cycle ops complete in one clock; MUL takes WIDTH+1 clocks.

Parameters:
- WIDTH, 32, operand/result width in bits (≥4).
- CW, $clog2(WIDTH)+1, multiplier iteration counter width (derived, not overridable).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operation request
- in_ready  output  1  block can accept a request this cycle
- opcode  input  3  operation select
- operand1  input  WIDTH  A operand
- operand2  input  WIDTH  B operand
- out_valid  output  1  one-cycle pulse: result/flags updated
- result  output  WIDTH  registered result
- flag_c  output  1  carry / borrow / multiply-overflow
- flag_z  output  1  result == 0
- flag_v  output  1  signed overflow
- flag_n  output  1  result[WIDTH-1]
- busy  output  1  multiplier in progress

Behaviour:
- Opcodes:
  - 000 AND, 001 OR, 010 ADD, 011 SUB, 100 SLT.
  - SLT: unsigned A<B gives 1, else 0, zero-extended.
  - 101 XOR, 110 MUL (low WIDTH bits of the unsigned product), 111 reserved.
- Reset (rst=1 at clock edge):
  - state=IDLE; result=0; all flags=0; out_valid=0; busy=0.
  - Iteration counter and partial product cleared.
  - Reset wins over every other event, including mid-MUL: the operation is aborted with no out_valid.
- Handshake:
  - Accept when in_valid & in_ready at a clock edge; opcode and operands are captured then.
  - in_ready = (state==IDLE), combinational from state.
  - No output backpressure: out_valid is a single-cycle pulse and the consumer must sample it.
- FSM IDLE:
  - Accept of a single-cycle op (000–101, 111): result/flags computed from the inputs and registered at the same edge; out_valid=1 the next cycle (latency 1); state stays IDLE.
  - Back-to-back accepts on consecutive cycles are legal; out_valid then stays high continuously.
  - Accept of MUL: latch A into the multiplicand register and B into the multiplier register; clear the product accumulator; counter=WIDTH; state→MUL; busy=1.
- FSM MUL: each cycle:
  - If mult[0]: acc += mcand, using a 2*WIDTH-bit accumulator.
  - Then mcand <<= 1, mult >>= 1, counter -= 1.
  - When the counter reaches 0 after the WIDTH-th iteration: register result=acc[WIDTH-1:0] and flags; out_valid=1; busy=0; state→IDLE.
  - Accept edge at cycle T gives out_valid at cycle T+WIDTH+1.
  - in_valid is ignored while busy.
- Flags (computed on the result being registered):
  - flag_z = (result==0); flag_n = result[WIDTH-1].
  - ADD: flag_c = carry out of bit WIDTH-1; flag_v = (A[msb]==B[msb]) & (R[msb]!=A[msb]).
  - SUB: flag_c = borrow (A<B unsigned); flag_v = (A[msb]!=B[msb]) & (R[msb]!=A[msb]).
  - MUL: flag_c = flag_v = |acc[2*WIDTH-1:WIDTH].
  - All other ops: flag_c=0, flag_v=0.
  - Reserved 111: result=0, all flags 0 (flag_z also 0), out_valid still pulses.
- Hold: result and flags keep their last value between completions; they do not change while a MUL is in progress.
- Width rules:
  - All arithmetic is modulo 2^WIDTH except the internal 2*WIDTH-bit accumulator.
  - No X-propagation: every register has a reset value.

Test Plan:
- Reset then idle: rst high 2 cycles → result=0, all flags 0, in_ready=1, busy=0, out_valid=0.
- ADD wrap (WIDTH=32): A=0xFFFFFFFF, B=1 → next cycle out_valid=1, result=0, flag_c=1, flag_z=1, flag_v=0, flag_n=0. Then A=0x7FFFFFFF, B=1 → result=0x80000000, flag_v=1, flag_n=1, flag_c=0.
- SUB/SLT/XOR back-to-back on 3 consecutive cycles:
  - SUB 5−7 → 0xFFFFFFFE, flag_c=1, flag_n=1.
  - SLT 5,7 → 1.
  - XOR 0xF0F0F0F0^0xFFFFFFFF → 0x0F0F0F0F.
  - out_valid high for 3 consecutive cycles.
- MUL latency/handshake: A=12345, B=678 at cycle T:
  - in_ready=0 and busy=1 during T+1..T+32; in_valid pulses during this window are ignored.
  - out_valid at T+33, result=8369910, flag_c=0.
- MUL overflow: A=0x10000, B=0x10000 → result=0, flag_z=1, flag_c=1, flag_v=1.
- Reset mid-MUL: start MUL, assert rst at iteration 10 → no out_valid, result and flags = 0, in_ready=1 the cycle after reset deasserts; a following ADD 2+3 returns 5.

Source files
------------

// File: rtl/alu_seq_param.sv
// Registered ALU with valid/ready request handshake, an iterative shift-add multiplier
// and carry/zero/overflow/negative flags; results and flags hold between completions.
module alu_seq_param #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       opcode,
   input  logic [WIDTH-1:0] operand1,
   input  logic [WIDTH-1:0] operand2,
   output logic             out_valid,
   output logic [WIDTH-1:0] result,
   output logic             flag_c,
   output logic             flag_z,
   output logic             flag_v,
   output logic             flag_n,
   output logic             busy
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;
   localparam int unsigned W2 = 2 * WIDTH;

   typedef enum logic [0:0] {StIdle, StMul} state_e;

   state_e          state_q;
   logic [W2-1:0]    mcand_q;
   logic [W2-1:0]    acc_q;
   logic [WIDTH-1:0] mult_q;
   logic [CW-1:0]    cnt_q;

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] op_res;
   logic             op_c;
   logic             op_v;
   logic             op_z;
   logic [W2-1:0]    acc_nxt;
   logic             mul_ovf;

   assign in_ready = (state_q == StIdle);

   // Single-cycle datapath, evaluated directly on the request inputs.
   always_comb begin
      sum    = {1'b0, operand1} + {1'b0, operand2};
      diff   = {1'b0, operand1} - {1'b0, operand2};
      op_res = '0;
      op_c   = 1'b0;
      op_v   = 1'b0;
      unique case (opcode)
         3'b000: op_res = operand1 & operand2;
         3'b001: op_res = operand1 | operand2;
         3'b010: begin
            op_res = sum[WIDTH-1:0];
            op_c   = sum[WIDTH];
            op_v   = (operand1[WIDTH-1] == operand2[WIDTH-1]) &&
                     (sum[WIDTH-1] != operand1[WIDTH-1]);
         end
         3'b011: begin
            op_res = diff[WIDTH-1:0];
            op_c   = diff[WIDTH];
            op_v   = (operand1[WIDTH-1] != operand2[WIDTH-1]) &&
                     (diff[WIDTH-1] != operand1[WIDTH-1]);
         end
         3'b100: op_res = {{(WIDTH-1){1'b0}}, diff[WIDTH]};
         3'b101: op_res = operand1 ^ operand2;
         default: op_res = '0;
      endcase
      // Reserved opcode reports all flags clear, including zero.
      op_z = (op_res == '0) && (opcode != 3'b111);
   end

   always_comb begin
      acc_nxt = acc_q + (mult_q[0] ? mcand_q : '0);
      mul_ovf = |acc_nxt[W2-1:WIDTH];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         mcand_q   <= '0;
         acc_q     <= '0;
         mult_q    <= '0;
         cnt_q     <= '0;
         result    <= '0;
         flag_c    <= 1'b0;
         flag_z    <= 1'b0;
         flag_v    <= 1'b0;
         flag_n    <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  if (opcode == 3'b110) begin
                     mcand_q <= {{WIDTH{1'b0}}, operand1};
                     mult_q  <= operand2;
                     acc_q   <= '0;
                     cnt_q   <= CW'(WIDTH);
                     busy    <= 1'b1;
                     state_q <= StMul;
                  end else begin
                     result    <= op_res;
                     flag_c    <= op_c;
                     flag_z    <= op_z;
                     flag_v    <= op_v;
                     flag_n    <= op_res[WIDTH-1];
                     out_valid <= 1'b1;
                  end
               end
            end
            StMul: begin
               acc_q   <= acc_nxt;
               mcand_q <= mcand_q << 1;
               mult_q  <= mult_q >> 1;
               cnt_q   <= cnt_q - CW'(1);
               // Last iteration: publish the final accumulator in the same edge.
               if (cnt_q == CW'(1)) begin
                  result    <= acc_nxt[WIDTH-1:0];
                  flag_c    <= mul_ovf;
                  flag_v    <= mul_ovf;
                  flag_z    <= (acc_nxt[WIDTH-1:0] == '0);
                  flag_n    <= acc_nxt[WIDTH-1];
                  out_valid <= 1'b1;
                  busy      <= 1'b0;
                  state_q   <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq_param.sv
// Self-checking bench for alu_seq_param (WIDTH=32): directed corner cases plus randomized
// operations compared against an arithmetic reference model.
module tb_alu_seq_param;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  opcode;
   logic [31:0] operand1;
   logic [31:0] operand2;
   logic        out_valid;
   logic [31:0] result;
   logic        flag_c;
   logic        flag_z;
   logic        flag_v;
   logic        flag_n;
   logic        busy;

   int checks = 0;
   int errors = 0;

   alu_seq_param #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
      .operand1(operand1), .operand2(operand2), .out_valid(out_valid), .result(result),
      .flag_c(flag_c), .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // {out_valid, result, c, z, v, n}
   function automatic logic [36:0] obs();
      return {out_valid, result, flag_c, flag_z, flag_v, flag_n};
   endfunction

   // Reference: {result, c, z, v, n} from plain integer arithmetic.
   function automatic logic [35:0] model(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      longint unsigned ua = 64'(a);
      longint unsigned ub = 64'(b);
      longint          sa = longint'($signed(a));
      longint          sb = longint'($signed(b));
      longint unsigned prod;
      logic [31:0]     r = '0;
      logic            c = 1'b0;
      logic            v = 1'b0;
      case (op)
         3'd0: r = a & b;
         3'd1: r = a | b;
         3'd2: begin
            r = a + b;
            c = (ua + ub) > 64'hFFFF_FFFF;
            v = (sa + sb) != longint'($signed(r));
         end
         3'd3: begin
            r = a - b;
            c = ua < ub;
            v = (sa - sb) != longint'($signed(r));
         end
         3'd4: r = (ua < ub) ? 32'd1 : 32'd0;
         3'd5: r = a ^ b;
         3'd6: begin
            prod = ua * ub;
            r = prod[31:0];
            c = prod[63:32] != 0;
            v = c;
         end
         default: r = '0;
      endcase
      return {r, c, (r == 0) && (op != 3'd7), v, r[31]};
   endfunction

   function automatic logic [31:0] rnd_operand();
      case ($urandom_range(0, 5))
         0: return 32'hFFFF_FFFF;
         1: return 32'h8000_0000;
         2: return 32'h7FFF_FFFF;
         3: return 32'(($urandom_range(0, 15)));
         default: return $urandom;
      endcase
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if ({obs(), in_ready, busy} !== {37'd0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL reset_state: got %h ready=%b busy=%b expected 0 ready=1 busy=0",
                  obs(), in_ready, busy);
      end
      rst = 1'b0;
      tick();
      checks++;
      if ({obs(), in_ready, busy} !== {37'd0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL reset_idle: got %h ready=%b busy=%b expected 0 ready=1 busy=0",
                  obs(), in_ready, busy);
      end
   endtask

   task automatic test_add_wrap();
      in_valid = 1'b1; opcode = 3'b010; operand1 = 32'hFFFF_FFFF; operand2 = 32'd1;
      tick();
      checks++;
      if (obs() !== {1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL add_carry: got %h expected %h", obs(),
                  {1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0});
      end
      operand1 = 32'h7FFF_FFFF;
      tick();
      in_valid = 1'b0;
      checks++;
      if (obs() !== {1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL add_overflow: got %h expected %h", obs(),
                  {1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b1});
      end
   endtask

   task automatic test_back_to_back();
      in_valid = 1'b1; opcode = 3'b011; operand1 = 32'd5; operand2 = 32'd7;
      tick();
      checks++;
      if (obs() !== {1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL b2b_sub: got %h expected %h", obs(),
                  {1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 1'b1});
      end
      opcode = 3'b100;
      tick();
      checks++;
      if (obs() !== {1'b1, 32'd1, 4'b0000}) begin
         errors++;
         $display("FAIL b2b_slt: got %h expected %h", obs(), {1'b1, 32'd1, 4'b0000});
      end
      opcode = 3'b101; operand1 = 32'hF0F0_F0F0; operand2 = 32'hFFFF_FFFF;
      tick();
      in_valid = 1'b0;
      checks++;
      if (obs() !== {1'b1, 32'h0F0F_0F0F, 4'b0000}) begin
         errors++;
         $display("FAIL b2b_xor: got %h expected %h", obs(), {1'b1, 32'h0F0F_0F0F, 4'b0000});
      end
      tick();
      checks++;
      if (obs() !== {1'b0, 32'h0F0F_0F0F, 4'b0000}) begin
         errors++;
         $display("FAIL b2b_hold: got %h expected %h", obs(), {1'b0, 32'h0F0F_0F0F, 4'b0000});
      end
   endtask

   task automatic test_random_single();
      logic [35:0] exp;
      logic [2:0]  op;
      for (int i = 0; i < 60; i++) begin
         op = 3'($urandom_range(0, 6));
         if (op == 3'd6) op = 3'd7;
         in_valid = 1'b1; opcode = op; operand1 = rnd_operand(); operand2 = rnd_operand();
         exp = model(op, operand1, operand2);
         tick();
         in_valid = 1'b0;
         checks++;
         if (obs() !== {1'b1, exp}) begin
            errors++;
            $display("FAIL rand_op%0d a=%h b=%h: got %h expected %h", op, operand1, operand2,
                     obs(), {1'b1, exp});
         end
         if ($urandom_range(0, 2) == 0) begin
            opcode = 3'($urandom); operand1 = $urandom; operand2 = $urandom;
            tick();
            checks++;
            if (obs() !== {1'b0, exp}) begin
               errors++;
               $display("FAIL rand_hold: got %h expected %h", obs(), {1'b0, exp});
            end
         end
      end
   endtask

   task automatic test_mul_latency();
      logic [36:0] held;
      held = obs();
      held[36] = 1'b0;
      in_valid = 1'b1; opcode = 3'b110; operand1 = 32'd12345; operand2 = 32'd678;
      tick();
      for (int i = 1; i <= 32; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         opcode = 3'b010; operand1 = $urandom; operand2 = $urandom;
         checks++;
         if ({in_ready, busy, obs()} !== {1'b0, 1'b1, held}) begin
            errors++;
            $display("FAIL mul_busy cycle %0d: ready=%b busy=%b out=%h expected 0/1/%h",
                     i, in_ready, busy, obs(), held);
         end
         tick();
      end
      in_valid = 1'b0;
      checks++;
      if ({in_ready, busy, obs()} !== {1'b1, 1'b0, 1'b1, 32'd8369910, 4'b0000}) begin
         errors++;
         $display("FAIL mul_done: ready=%b busy=%b out=%h expected 1/0/%h", in_ready, busy,
                  obs(), {1'b1, 32'd8369910, 4'b0000});
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL mul_pulse: out_valid got %b expected 0", out_valid);
      end
   endtask

   task automatic test_mul_random();
      logic [35:0] exp;
      int          n;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; opcode = 3'b110;
         if (i == 0) begin
            operand1 = 32'h0001_0000; operand2 = 32'h0001_0000;
         end else begin
            operand1 = (i % 2 == 0) ? rnd_operand() : 32'($urandom_range(0, 65535));
            operand2 = (i % 2 == 0) ? rnd_operand() : 32'($urandom_range(0, 65535));
         end
         exp = model(3'b110, operand1, operand2);
         tick();
         in_valid = 1'b0;
         n = 1;
         while (!out_valid && n < 40) begin
            tick();
            n++;
         end
         checks++;
         if ({n, obs()} !== {33, 1'b1, exp}) begin
            errors++;
            $display("FAIL mul_rand a=%h b=%h: latency %0d out %h expected latency 33 out %h",
                     operand1, operand2, n, obs(), {1'b1, exp});
         end
      end
   endtask

   task automatic test_reset_mid_mul();
      in_valid = 1'b1; opcode = 3'b110; operand1 = 32'hDEAD_BEEF; operand2 = 32'h1234_5678;
      tick();
      in_valid = 1'b0;
      repeat (10) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if ({obs(), in_ready, busy} !== {37'd0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL mid_mul_reset: got %h ready=%b busy=%b expected 0 ready=1 busy=0",
                  obs(), in_ready, busy);
      end
      for (int i = 0; i < 30; i++) begin
         tick();
         checks++;
         if ({obs(), in_ready} !== {37'd0, 1'b1}) begin
            errors++;
            $display("FAIL mid_mul_abort cycle %0d: got %h ready=%b expected 0 ready=1",
                     i, obs(), in_ready);
         end
      end
      in_valid = 1'b1; opcode = 3'b010; operand1 = 32'd2; operand2 = 32'd3;
      tick();
      in_valid = 1'b0;
      checks++;
      if (obs() !== {1'b1, 32'd5, 4'b0000}) begin
         errors++;
         $display("FAIL post_reset_add: got %h expected %h", obs(), {1'b1, 32'd5, 4'b0000});
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; opcode = '0; operand1 = '0; operand2 = '0;
      test_reset();
      test_add_wrap();
      test_back_to_back();
      test_random_single();
      test_mul_latency();
      test_mul_random();
      test_reset_mid_mul();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
